// File: rtl/dmau_pkg.sv
// rtl/dmau_pkg.sv - shared types and alignment helper for the data memory access unit
package dmau_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } dmau_state_t;

    // Reserved size encoding 2'b11 never passes, so it is rejected like a misaligned access.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~off[0];
            SZ_W:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - byte strobes and lane-replicated store data for one access
module store_lane_align
    import dmau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_wdata
);

    // Data is replicated across lanes so the strobes alone select the written bytes.
    always_comb begin
        wstrb      = 4'b0000;
        lane_wdata = 32'h0;
        case (size)
            SZ_B: begin
                wstrb      = 4'b0001 << offset;
                lane_wdata = {4{wdata[7:0]}};
            end
            SZ_H: begin
                wstrb      = 4'b0011 << offset;
                lane_wdata = {2{wdata[15:0]}};
            end
            SZ_W: begin
                wstrb      = 4'b1111;
                lane_wdata = wdata;
            end
            default: begin
                wstrb      = 4'b0000;
                lane_wdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// rtl/data_mem_access_unit.sv - load/store request/grant/response engine with timeout
module data_mem_access_unit
    import dmau_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err,
    output logic [31:0] load_word,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    dmau_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off_q;
    logic             req_ok;
    logic             at_limit;
    logic [3:0]       lane_strb;
    logic [31:0]      lane_wdata;

    assign req_ok   = is_aligned(req_size, req_addr[1:0]);
    assign at_limit = (cnt == LIMIT);
    assign busy     = (state != IDLE);

    store_lane_align u_store_lane_align (
        .size       (req_size),
        .offset     (req_addr[1:0]),
        .wdata      (req_wdata),
        .wstrb      (lane_strb),
        .lane_wdata (lane_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A grant or response arriving on the limit cycle takes priority over the abort.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid && req_ok) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (mem_gnt)       state_nxt = mem_we ? IDLE : WAIT;
                else if (at_limit) state_nxt = IDLE;
            end
            WAIT: begin
                if (mem_rvalid || at_limit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            load_word  <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wstrb  <= 4'b0000;
            mem_wdata  <= 32'h0;
            cnt        <= '0;
            off_q      <= 2'b00;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_ok) begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wstrb <= req_write ? lane_strb : 4'b0000;
                            mem_wdata <= lane_wdata;
                            off_q     <= req_addr[1:0];
                            cnt       <= '0;
                        end else begin
                            misaligned <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        done    <= mem_we;
                    end else if (at_limit) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_rvalid) begin
                        load_word <= mem_rdata >> {off_q, 3'b000};
                        done      <= 1'b1;
                    end else if (at_limit) begin
                        bus_err <= 1'b1;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
